hash_core_arbiter: RTL and testbench
====================================

Name: hash_core_arbiter

Overview:
- Shares one byte-serial DES-S-box hash core among NREQ requesters.
- Each requester submits one whole message: a byte stream plus its 64-bit length.
- The arbiter grants requesters round-robin and locks the core to the winner for the full message. It drives the core's byte/length interface, waits for the core's digest, and returns the digest tagged with the requester ID.
- A watchdog recovers from a core that never signals completion.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width (at least clog2(NREQ)).
- TIMEOUT, 64, max cycles in WAIT before the watchdog aborts.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  8*NREQ  per-requester byte; slice i is [8i+7:8i].
- req_len  in  64*NREQ  per-requester message length in bytes; must be stable while req_valid is high.
- req_ready  out  NREQ  per-requester byte accepted.
- core_m_valid  out  1  byte valid toward the core.
- core_message  out  8  byte toward the core.
- core_counter  out  64  latched length toward the core; held for the whole message.
- core_m_ready  in  1  core accepts a byte.
- core_hash_ready  in  1  core digest-valid pulse.
- core_digest  in  32  core digest.
- digest_out  out  32  registered digest.
- digest_valid  out  1  one-cycle pulse.
- digest_id  out  IDW  owner of digest_out.
- err_zero_len  out  1  one-cycle pulse: the granted request had len 0.
- err_timeout  out  1  one-cycle pulse: watchdog fired.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async, active-low) values:
  - state=IDLE, rr_ptr=0.
  - All outputs 0; core_counter=0, digest_out=0, digest_id=0.
  - remaining count 0, watchdog 0.
  - Reset mid-message abandons it; the core is not notified.
- State IDLE:
  - If any req_valid is high, pick the first set bit searching from rr_ptr upward, with wrap-around.
  - Register gnt_id; latch len = req_len[gnt_id]; core_counter = len.
  - If len == 0: pulse err_zero_len next cycle, set rr_ptr = gnt_id+1 (mod NREQ), stay IDLE, consume no bytes.
  - Otherwise go to XFER.
  - Grant decision takes effect the cycle after req_valid is seen.
- State XFER:
  - Combinational pass-through: core_m_valid = req_valid[gnt_id], core_message = req_data[gnt_id].
  - req_ready[gnt_id] = core_m_ready; all other req_ready bits are 0.
  - On each handshake (valid & ready), remaining decrements.
  - Handshake with remaining == 1 → WAIT.
  - Requester dropping valid mid-message: stall; no timeout in XFER.
  - Other requesters' valids are ignored until DONE.
  - core_hash_ready while in XFER is ignored (protocol violation, not flagged).
- State WAIT:
  - core_m_valid = 0; watchdog increments each cycle.
  - core_hash_ready → capture core_digest into digest_out, digest_id = gnt_id, go to DONE.
  - Watchdog reaching TIMEOUT-1 without core_hash_ready → pulse err_timeout, go to IDLE.
  - Watchdog is cleared on leaving WAIT.
- State DONE:
  - digest_valid = 1 for exactly this cycle; rr_ptr = gnt_id+1 (mod NREQ); → IDLE.
  - digest_out and digest_id hold until the next capture.
- Fairness and throughput:
  - rr_ptr advances only on completion, zero-length rejection or timeout.
  - Minimum turnaround between messages: 2 cycles (DONE, IDLE).
- Widths:
  - remaining is 64-bit and never wraps, since the length-0 case is rejected.
  - rr_ptr wrap is modulo NREQ, which is not necessarily a power of two.
- core_counter changes only on a grant in IDLE.

Test Plan:
1. Single requester 1, len=3, bytes "abc", core_m_ready=1, core returns 0xDEADBEEF 5 cycles after the last byte → 3 handshakes, core_counter=3 throughout, digest_valid one cycle with digest_out=0xDEADBEEF, digest_id=1.
2. Requesters 0,2,3 valid simultaneously from reset, each len=2 → grant order 0,2,3. Then with 0 and 3 valid again → 0 granted next (pointer at 0 after wrap from 3); no req_ready bit asserts for non-owners.
3. Requester 2 len=4 with core_m_ready toggling 1,0,1,0 and req_valid gap of 3 cycles mid-message → exactly 4 handshakes, core_message matches sent bytes in order, no error.
4. Requester 0 len=0 with requester 1 len=1 valid → err_zero_len pulse, req_ready[0] never high, requester 1 granted next.
5. Requester 3 len=1, core never asserts core_hash_ready → err_timeout pulses after exactly TIMEOUT cycles in WAIT, digest_valid stays 0, busy=0 afterwards, rr_ptr=0.
6. rst_n low for 1 cycle during XFER of an 8-byte message → all outputs 0 immediately (asynchronous), state IDLE; a new len=1 message afterwards completes normally with grant from index 0.

Source files
------------

// File: rtl/hash_core_arbiter.sv
// hash_core_arbiter
//   Shares one byte-serial hash core among NREQ requesters. Requesters are
//   granted round-robin. The winner keeps the core for its whole message,
//   including the wait for the digest. The digest comes back tagged with the
//   owner's ID. A watchdog abandons a core that never reports completion.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/ready        per-requester byte handshake
//   req_data               per-requester byte, slice i = [8i+7:8i]
//   req_len                per-requester message length, slice i = [64i+63:64i]
//   core_m_valid/ready     byte handshake toward the core
//   core_message           byte toward the core
//   core_counter           length of the granted message, held until next grant
//   core_hash_ready        core digest-valid pulse
//   core_digest            core digest
//   digest_out/id/valid    registered digest, its owner, one-cycle valid pulse
//   err_zero_len           one-cycle pulse: a granted request had length 0
//   err_timeout            one-cycle pulse: watchdog gave up on the core
//   busy                   arbiter is not idle
module hash_core_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_data,
    input  logic [64*NREQ-1:0]   req_len,
    output logic [NREQ-1:0]      req_ready,
    output logic                 core_m_valid,
    output logic [7:0]           core_message,
    output logic [63:0]          core_counter,
    input  logic                 core_m_ready,
    input  logic                 core_hash_ready,
    input  logic [31:0]          core_digest,
    output logic [31:0]          digest_out,
    output logic                 digest_valid,
    output logic [IDW-1:0]       digest_id,
    output logic                 err_zero_len,
    output logic                 err_timeout,
    output logic                 busy
);
    // Request slots are padded to a power of two so an IDW-bit index is
    // always in range; padding slots never request.
    localparam int NSLOT = 1 << IDW;
    localparam int WDW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [63:0]    remaining_q, remaining_d;
    logic [63:0]    counter_q, counter_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic [31:0]    digest_q, digest_d;
    logic [IDW-1:0] digest_id_q, digest_id_d;
    logic           err_zero_q, err_zero_d;
    logic           err_to_q, err_to_d;

    logic [NSLOT-1:0] valid_arr;
    logic [7:0]       data_arr [NSLOT];
    logic [63:0]      len_arr  [NSLOT];

    logic             any_valid;
    logic             have_hi;
    logic [IDW-1:0]   pick_hi, pick_lo, pick;

    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        if (gi < NREQ) begin : g_real
            assign valid_arr[gi] = req_valid[gi];
            assign data_arr[gi]  = req_data[8*gi +: 8];
            assign len_arr[gi]   = req_len[64*gi +: 64];
        end else begin : g_pad
            assign valid_arr[gi] = 1'b0;
            assign data_arr[gi]  = 8'd0;
            assign len_arr[gi]   = 64'd0;
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = (state_q == S_XFER) && (gnt_id_q == IDW'(gi)) && core_m_ready;
    end

    // Round-robin pick: the lowest requesting index at or above rr_ptr wins;
    // if none, the lowest requesting index overall (the wrap-around case).
    // Scanning downward lets the last hit be the lowest index.
    always_comb begin
        any_valid = 1'b0;
        have_hi   = 1'b0;
        pick_hi   = '0;
        pick_lo   = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (valid_arr[i[IDW-1:0]]) begin
                any_valid = 1'b1;
                pick_lo   = i[IDW-1:0];
                if (i[IDW-1:0] >= rr_ptr_q) begin
                    have_hi = 1'b1;
                    pick_hi = i[IDW-1:0];
                end
            end
        end
        pick = have_hi ? pick_hi : pick_lo;
    end

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
    endfunction

    always_comb begin
        core_m_valid = (state_q == S_XFER) && valid_arr[gnt_id_q];
        core_message = (state_q == S_XFER) ? data_arr[gnt_id_q] : 8'd0;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_id_d    = gnt_id_q;
        remaining_d = remaining_q;
        counter_d   = counter_q;
        wdog_d      = wdog_q;
        digest_d    = digest_q;
        digest_id_d = digest_id_q;
        err_zero_d  = 1'b0;
        err_to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    gnt_id_d    = pick;
                    counter_d   = len_arr[pick];
                    remaining_d = len_arr[pick];
                    if (len_arr[pick] == 64'd0) begin
                        // Rejected without moving a byte; the pointer still
                        // advances so a stuck zero-length requester cannot
                        // starve the others.
                        err_zero_d = 1'b1;
                        rr_ptr_d   = next_id(pick);
                    end else begin
                        state_d = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (core_m_valid && core_m_ready) begin
                    remaining_d = remaining_q - 64'd1;
                    if (remaining_q == 64'd1) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (core_hash_ready) begin
                    digest_d    = core_digest;
                    digest_id_d = gnt_id_q;
                    wdog_d      = '0;
                    state_d     = S_DONE;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    wdog_d   = '0;
                    rr_ptr_d = next_id(gnt_id_q);
                    state_d  = S_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_DONE: begin
                rr_ptr_d = next_id(gnt_id_q);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_id_q    <= '0;
            remaining_q <= '0;
            counter_q   <= '0;
            wdog_q      <= '0;
            digest_q    <= '0;
            digest_id_q <= '0;
            err_zero_q  <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_id_q    <= gnt_id_d;
            remaining_q <= remaining_d;
            counter_q   <= counter_d;
            wdog_q      <= wdog_d;
            digest_q    <= digest_d;
            digest_id_q <= digest_id_d;
            err_zero_q  <= err_zero_d;
            err_to_q    <= err_to_d;
        end
    end

    assign core_counter = counter_q;
    assign digest_out   = digest_q;
    assign digest_id    = digest_id_q;
    assign digest_valid = (state_q == S_DONE);
    assign err_zero_len = err_zero_q;
    assign err_timeout  = err_to_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_hash_core_arbiter.sv
// Randomized bench for hash_core_arbiter. Each round loads a set of
// requester messages. The expected service order comes from round-robin
// arithmetic on a message-level pointer. A small core model returns a
// digest after a random delay, or hangs so that the watchdog fires.
module tb_hash_core_arbiter;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;
    localparam int MAXB    = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [8*NREQ-1:0]   req_data;
    logic [64*NREQ-1:0]  req_len;
    logic [NREQ-1:0]     req_ready;
    logic                core_m_valid;
    logic [7:0]          core_message;
    logic [63:0]         core_counter;
    logic                core_m_ready;
    logic                core_hash_ready;
    logic [31:0]         core_digest;
    logic [31:0]         digest_out;
    logic                digest_valid;
    logic [IDW-1:0]      digest_id;
    logic                err_zero_len;
    logic                err_timeout;
    logic                busy;

    always #5 clk = ~clk;

    hash_core_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_len(req_len),
        .req_ready(req_ready),
        .core_m_valid(core_m_valid), .core_message(core_message),
        .core_counter(core_counter), .core_m_ready(core_m_ready),
        .core_hash_ready(core_hash_ready), .core_digest(core_digest),
        .digest_out(digest_out), .digest_valid(digest_valid),
        .digest_id(digest_id), .err_zero_len(err_zero_len),
        .err_timeout(err_timeout), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Per-requester message state.
    logic [63:0] r_len   [NREQ];
    logic [7:0]  r_bytes [NREQ][MAXB];
    logic [31:0] r_dig   [NREQ];
    bit          r_hang  [NREQ];
    int          r_delay [NREQ];
    int          r_sent  [NREQ];
    bit          r_pend  [NREQ];

    int exp_q[$];     // expected service order (requester ids)
    int m_rr = 0;     // message-level round-robin pointer
    bit core_act = 1'b0;
    int core_cnt = 0;
    int core_id  = 0;
    int last_hs  = 0;
    bit idle_chk = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs_zero();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_core_m_valid", core_m_valid, 0);
        check_eq("rst_core_message", core_message, 0);
        check_eq("rst_core_counter", core_counter, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_digest_out", digest_out, 0);
        check_eq("rst_digest_valid", digest_valid, 0);
        check_eq("rst_digest_id", digest_id, 0);
        check_eq("rst_err_zero_len", err_zero_len, 0);
        check_eq("rst_err_timeout", err_timeout, 0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) begin
            r_pend[i] = 1'b0;
            r_sent[i] = 0;
            r_len[i]  = 64'd0;
        end
        core_act = 1'b0;
        idle_chk = 1'b0;
        m_rr     = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        core_m_ready = 1'b0;
        core_hash_ready = 1'b0;
        clear_model();
        #1;
        check_outputs_zero();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_req(input int id, input int len, input bit hang);
        r_len[id] = 64'(len);
        for (int b = 0; b < MAXB; b++) r_bytes[id][b] = 8'($urandom);
        r_dig[id]   = $urandom;
        r_hang[id]  = hang;
        r_delay[id] = $urandom_range(0, 8);
        r_sent[id]  = 0;
        r_pend[id]  = 1'b1;
    endtask

    // Service order: repeatedly take the first pending id at or after the
    // pointer (wrapping), then move the pointer just past it.
    task automatic plan();
        bit in_set[NREQ];
        int left = 0;
        for (int i = 0; i < NREQ; i++) begin
            in_set[i] = r_pend[i];
            if (r_pend[i]) left++;
        end
        while (left > 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (m_rr + k) % NREQ;
                if (in_set[idx]) begin
                    exp_q.push_back(idx);
                    in_set[idx] = 1'b0;
                    m_rr = (idx + 1) % NREQ;
                    left--;
                    break;
                end
            end
        end
    endtask

    // 0: nothing expected, 1: zero-length reject, 2: digest, 3: timeout
    function automatic int head_type();
        int id;
        if (exp_q.size() == 0) return 0;
        id = exp_q[0];
        if (r_len[id] == 64'd0) return 1;
        if (r_hang[id]) return 3;
        return 2;
    endfunction

    task automatic cycle();
        int h;
        int id;
        logic [NREQ-1:0] allow;
        @(negedge clk);
        cyc++;
        h  = head_type();
        id = (exp_q.size() > 0) ? exp_q[0] : 0;

        // Outputs produced by the previous rising edge.
        if (idle_chk) begin
            check_eq("busy_after_done", busy, 0);
            idle_chk = 1'b0;
        end
        if (err_zero_len) begin
            check_eq("event_kind_zero", 1, h);
            if (h == 1) begin
                $display("txn id=%0d len=0 rejected (zero length)", id);
                check_eq("busy_after_zero", busy, 0);
                r_pend[id] = 1'b0;
                void'(exp_q.pop_front());
            end
        end
        if (digest_valid) begin
            check_eq("event_kind_digest", 2, h);
            if (h == 2) begin
                $display("txn id=%0d len=%0d digest=%08h", id, r_len[id], digest_out);
                check_eq("digest_out", digest_out, r_dig[id]);
                check_eq("digest_id", digest_id, id);
                check_eq("digest_latency", cyc - last_hs, r_delay[id] + 2);
                check_eq("busy_in_done", busy, 1);
                void'(exp_q.pop_front());
                idle_chk = 1'b1;
            end
        end
        if (err_timeout) begin
            check_eq("event_kind_timeout", 3, h);
            if (h == 3) begin
                $display("txn id=%0d len=%0d timed out", id, r_len[id]);
                check_eq("timeout_latency", cyc - last_hs, TIMEOUT + 1);
                check_eq("busy_after_timeout", busy, 0);
                check_eq("no_digest_on_timeout", digest_valid, 0);
                void'(exp_q.pop_front());
            end
        end

        h  = head_type();
        id = (exp_q.size() > 0) ? exp_q[0] : 0;

        // Drive requesters: waiting requesters hold valid; the owner may
        // insert gaps once it has moved at least one byte.
        for (int i = 0; i < NREQ; i++) begin
            req_len[64*i +: 64] = r_len[i];
            if (r_pend[i] && r_len[i] == 64'd0) begin
                req_valid[i] = 1'b1;
                req_data[8*i +: 8] = 8'($urandom);
            end else if (r_pend[i] && 64'(r_sent[i]) < r_len[i]) begin
                req_valid[i] = (r_sent[i] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                req_data[8*i +: 8] = r_bytes[i][r_sent[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_data[8*i +: 8] = 8'($urandom);
            end
        end
        core_m_ready    = ($urandom_range(0, 3) != 0);
        core_hash_ready = 1'b0;
        core_digest     = $urandom;
        if (core_act) begin
            if (core_cnt == 0) begin
                core_hash_ready = 1'b1;
                core_digest     = r_dig[core_id];
                core_act        = 1'b0;
            end else begin
                core_cnt--;
            end
        end else if ((h == 2 || h == 3) && r_sent[id] > 0 && 64'(r_sent[id]) < r_len[id]) begin
            // Stray completion mid-transfer must be ignored.
            core_hash_ready = ($urandom_range(0, 7) == 0);
        end

        #1;
        allow = '0;
        if ((h == 2 || h == 3) && 64'(r_sent[id]) < r_len[id]) allow[id] = 1'b1;
        check_eq("ready_owner_only", req_ready & ~allow, 0);
        if ((h == 2 || h == 3) && r_sent[id] > 0 && 64'(r_sent[id]) < r_len[id])
            check_eq("m_valid_passthru", core_m_valid, req_valid[id]);
        if ((h == 2 || h == 3) && req_valid[id] && req_ready[id]) begin
            check_eq("hs_core_m_valid", core_m_valid, 1);
            check_eq("hs_core_message", core_message, r_bytes[id][r_sent[id]]);
            check_eq("hs_core_counter", core_counter, r_len[id]);
            r_sent[id]++;
            if (64'(r_sent[id]) == r_len[id]) begin
                last_hs    = cyc;
                r_pend[id] = 1'b0;
                if (!r_hang[id]) begin
                    core_act = 1'b1;
                    core_cnt = r_delay[id];
                    core_id  = id;
                end
            end
        end
    endtask

    task automatic run_round();
        int n = 0;
        plan();
        while (exp_q.size() != 0 && n < 3000) begin
            cycle();
            n++;
        end
        check_eq("round_drained", exp_q.size(), 0);
        if (exp_q.size() != 0) do_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int budget;
        int sent_before;
        bit any;
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_len = '0;
        core_m_ready = 1'b0;
        core_hash_ready = 1'b0;
        core_digest = '0;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        check_outputs_zero();
        @(negedge clk);
        rst_n = 1'b1;

        // Lone requester whose core never finishes: watchdog path.
        load_req(3, 1, 1'b1);
        run_round();
        // Zero-length request competing with a normal one.
        load_req(0, 0, 1'b0);
        load_req(1, 1, 1'b0);
        run_round();
        // Three simultaneous requesters, then two more.
        load_req(0, 2, 1'b0);
        load_req(2, 2, 1'b0);
        load_req(3, 2, 1'b0);
        run_round();
        load_req(0, 2, 1'b0);
        load_req(3, 2, 1'b0);
        run_round();

        // Asynchronous reset in the middle of an 8-byte transfer.
        load_req(2, 8, 1'b0);
        plan();
        budget = 0;
        while (r_sent[2] < 3 && budget < 400) begin
            cycle();
            budget++;
        end
        sent_before = r_sent[2];
        check_eq("reset_test_progress", sent_before >= 3, 1);
        do_reset();
        load_req(1, 1, 1'b0);
        load_req(3, 1, 1'b0);
        run_round();

        for (int r = 0; r < 40; r++) begin
            any = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    load_req(i, ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 6),
                             ($urandom_range(0, 7) == 0));
                    any = 1'b1;
                end
            end
            if (!any) load_req($urandom_range(0, NREQ - 1), $urandom_range(1, 6), 1'b0);
            run_round();
        end
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
